rv_muldiv: RTL and testbench

Parametrised iterative RISC-V M-extension unit executing MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU for an XLEN-wide core. It sits beside the core ALU, replacing the fixed 32-bit multiplier and divider pair with one shared controller behind valid/ready request and response channels. It implements the architectural divide-by-zero and overflow results, and has a configurable multiply radix.

---
 rtl/rv_muldiv_pkg.sv | 34 +++
 rtl/rv_muldiv_if.sv | 25 ++
 rtl/rv_div_step.sv | 27 ++
 rtl/rv_muldiv.sv | 210 +++++++++++++++++++++
 tb/tb_rv_muldiv.sv | 150 +++++++++++++++
 5 files changed

// File: rtl/rv_muldiv_pkg.sv
// Shared opcodes, FSM states and operand-signedness helpers for the iterative
// RISC-V M-extension multiply/divide unit.
package rv_muldiv_pkg;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIXUP,
    S_DONE
  } state_e;

  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic a_signed(input logic [2:0] op);
    return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
  endfunction

  function automatic logic b_signed(input logic [2:0] op);
    return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage

// File: rtl/rv_muldiv_if.sv
// Request/response channel bundle of the multiply/divide unit.
// master = issuing core, slave = rv_muldiv.
interface rv_muldiv_if #(
  parameter int unsigned XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_op;
  logic [XLEN-1:0] req_a;
  logic [XLEN-1:0] req_b;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_data;
  logic            busy;

  modport master (
    output req_valid, req_op, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_data, busy
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_data, busy
  );
endinterface

// File: rtl/rv_div_step.sv
// One radix-2 restoring-division iteration on unsigned magnitudes.
// quo carries the not-yet-consumed dividend bits in its top and the quotient in its bottom.
module rv_div_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_next,
  output logic [XLEN-1:0] quo_next
);
  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  always_comb begin
    shifted = {rem, quo[XLEN-1]};
    diff    = shifted - {1'b0, divisor};
    // rem < divisor keeps shifted < 2*divisor, so diff's top bit is a clean borrow flag.
    if (!diff[XLEN]) begin
      rem_next = diff[XLEN-1:0];
      quo_next = {quo[XLEN-2:0], 1'b1};
    end else begin
      rem_next = shifted[XLEN-1:0];
      quo_next = {quo[XLEN-2:0], 1'b0};
    end
  end
endmodule

// File: rtl/rv_muldiv.sv
// Iterative RV M-extension unit: shift-add multiply, restoring divide, sign fixup.
// Define RV_MULDIV_FUSE_EN to reuse the last division result for matching DIV/REM pairs.
module rv_muldiv
  import rv_muldiv_pkg::*;
#(
  parameter int unsigned XLEN               = 32,
  parameter int unsigned MUL_BITS_PER_CYCLE = 4
) (
  input logic        clk,
  input logic        rst,
  rv_muldiv_if.slave bus
);
  localparam int unsigned MulSteps = XLEN / MUL_BITS_PER_CYCLE;
  localparam int unsigned CntW     = $clog2(XLEN + 1);
  localparam int unsigned PpW      = XLEN + MUL_BITS_PER_CYCLE;
  localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state_q;
  logic [2:0]        op_q;
  logic              a_neg_q, b_neg_q;
  logic [XLEN-1:0]   a_mag_q, b_mag_q;
  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   quo_q, rem_q;
  logic [CntW-1:0]   cnt_q;
  logic [XLEN-1:0]   res_q;
  logic              resp_valid_q, busy_q;

  logic              a_neg_in, b_neg_in;
  logic [XLEN-1:0]   a_mag_in, b_mag_in;
  logic              div_zero, div_ovf, special;
  logic [XLEN-1:0]   special_res;
  logic              fuse_hit;
  logic [XLEN-1:0]   fuse_res;
  logic [PpW-1:0]    pp, mul_sum;
  logic [2*XLEN-1:0] acc_next, prod_f;
  logic [XLEN-1:0]   rem_next, quo_next, quo_f, rem_f, fix_res;

  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = res_q;
  assign bus.busy       = busy_q;

  // Accept-time decode: sign flags, magnitudes and the architectural special cases.
  always_comb begin
    a_neg_in = a_signed(bus.req_op) & bus.req_a[XLEN-1];
    b_neg_in = b_signed(bus.req_op) & bus.req_b[XLEN-1];
    a_mag_in = a_neg_in ? -bus.req_a : bus.req_a;
    b_mag_in = b_neg_in ? -bus.req_b : bus.req_b;
    div_zero = is_div(bus.req_op) && (bus.req_b == '0);
    div_ovf  = ((bus.req_op == MD_DIV) || (bus.req_op == MD_REM)) &&
               (bus.req_a == MinNeg) && (bus.req_b == '1);
    special  = div_zero || div_ovf;
    if (bus.req_op[1]) special_res = div_zero ? bus.req_a : '0;
    else               special_res = div_zero ? '1 : MinNeg;
  end

`ifdef RV_MULDIV_FUSE_EN
  logic            tag_valid_q, tag_sgn_q;
  logic [XLEN-1:0] tag_a_q, tag_b_q, tag_quo_q, tag_rem_q;

  always_comb begin
    fuse_hit = is_div(bus.req_op) && tag_valid_q && (bus.req_a == tag_a_q) &&
               (bus.req_b == tag_b_q) && (tag_sgn_q == !bus.req_op[0]);
    fuse_res = bus.req_op[1] ? tag_rem_q : tag_quo_q;
  end
`else
  assign fuse_hit = 1'b0;
  assign fuse_res = '0;
`endif

  // Multiplier bits sit in the low end of acc_q and shift out as the product shifts in.
  always_comb begin
    pp = '0;
    for (int i = 0; i < int'(MUL_BITS_PER_CYCLE); i++) begin
      if (acc_q[i]) pp = pp + (PpW'(a_mag_q) << i);
    end
    mul_sum = PpW'(acc_q[2*XLEN-1:XLEN]) + pp;
  end

  if (MUL_BITS_PER_CYCLE < XLEN) begin : g_acc_shift
    assign acc_next = {mul_sum, acc_q[XLEN-1:MUL_BITS_PER_CYCLE]};
  end else begin : g_acc_whole
    assign acc_next = mul_sum;
  end

  rv_div_step #(
    .XLEN(XLEN)
  ) u_div_step (
    .rem     (rem_q),
    .quo     (quo_q),
    .divisor (b_mag_q),
    .rem_next(rem_next),
    .quo_next(quo_next)
  );

  always_comb begin
    prod_f = (a_neg_q ^ b_neg_q) ? -acc_q : acc_q;
    quo_f  = (a_neg_q ^ b_neg_q) ? -quo_q : quo_q;
    rem_f  = a_neg_q ? -rem_q : rem_q;
    unique case (op_q)
      MD_MUL:                       fix_res = prod_f[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: fix_res = prod_f[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              fix_res = quo_f;
      default:                      fix_res = rem_f;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      op_q         <= '0;
      a_neg_q      <= 1'b0;
      b_neg_q      <= 1'b0;
      a_mag_q      <= '0;
      b_mag_q      <= '0;
      acc_q        <= '0;
      quo_q        <= '0;
      rem_q        <= '0;
      cnt_q        <= '0;
      res_q        <= '0;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
`ifdef RV_MULDIV_FUSE_EN
      tag_valid_q  <= 1'b0;
      tag_sgn_q    <= 1'b0;
      tag_a_q      <= '0;
      tag_b_q      <= '0;
      tag_quo_q    <= '0;
      tag_rem_q    <= '0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.req_valid) begin
            op_q    <= bus.req_op;
            a_neg_q <= a_neg_in;
            b_neg_q <= b_neg_in;
            a_mag_q <= a_mag_in;
            b_mag_q <= b_mag_in;
            busy_q  <= 1'b1;
            if (special) begin
              res_q        <= special_res;
              resp_valid_q <= 1'b1;
              state_q      <= S_DONE;
`ifdef RV_MULDIV_FUSE_EN
              tag_valid_q  <= 1'b1;
              tag_sgn_q    <= !bus.req_op[0];
              tag_a_q      <= bus.req_a;
              tag_b_q      <= bus.req_b;
              tag_quo_q    <= div_zero ? '1 : MinNeg;
              tag_rem_q    <= div_zero ? bus.req_a : '0;
`endif
            end else if (fuse_hit) begin
              res_q        <= fuse_res;
              resp_valid_q <= 1'b1;
              state_q      <= S_DONE;
            end else if (is_div(bus.req_op)) begin
              quo_q   <= a_mag_in;
              rem_q   <= '0;
              cnt_q   <= CntW'(XLEN);
              state_q <= S_DIV;
`ifdef RV_MULDIV_FUSE_EN
              // Tag operands are captured now; the tag only turns valid once results land.
              tag_valid_q <= 1'b0;
              tag_sgn_q   <= !bus.req_op[0];
              tag_a_q     <= bus.req_a;
              tag_b_q     <= bus.req_b;
`endif
            end else begin
              acc_q   <= {{XLEN{1'b0}}, b_mag_in};
              cnt_q   <= CntW'(MulSteps);
              state_q <= S_MUL;
            end
          end
        end
        S_MUL: begin
          acc_q <= acc_next;
          cnt_q <= cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) state_q <= S_FIXUP;
        end
        S_DIV: begin
          rem_q <= rem_next;
          quo_q <= quo_next;
          cnt_q <= cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) state_q <= S_FIXUP;
        end
        S_FIXUP: begin
          res_q        <= fix_res;
          resp_valid_q <= 1'b1;
          state_q      <= S_DONE;
`ifdef RV_MULDIV_FUSE_EN
          if (is_div(op_q)) begin
            tag_valid_q <= 1'b1;
            tag_quo_q   <= quo_f;
            tag_rem_q   <= rem_f;
          end
`endif
        end
        S_DONE: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rv_muldiv.sv
// Directed self-checking bench for rv_muldiv at XLEN=32, four multiplier bits per cycle.
module tb_rv_muldiv;
  import rv_muldiv_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  rv_muldiv_if #(.XLEN(32)) bus ();

  rv_muldiv #(
    .XLEN              (32),
    .MUL_BITS_PER_CYCLE(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents a request; returns #1 after the accepting edge with the inputs scrambled.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_op    = ~op;
    bus.req_a     = ~a;
    bus.req_b     = b ^ 32'h5A5A_5A5A;
  endtask

  // Cycle 1 is the one right after the accepting edge.
  task automatic wait_resp(output int lat);
    lat = 1;
    while (bus.resp_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic handshake();
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
  endtask

  task automatic run(input string tag, input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp_data, input int exp_lat);
    int lat;
    issue(op, a, b);
    check({tag, " busy/ready"}, {bus.busy, bus.req_ready}, 32'h2);
    wait_resp(lat);
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " data"}, bus.resp_data, exp_data);
    handshake();
    check({tag, " ack"}, {bus.resp_valid, bus.req_ready, bus.busy}, 32'h2);
  endtask

  initial begin
    int lat;
    int seen;
    rst            = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_op     = 3'b000;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset flags", {bus.req_ready, bus.resp_valid, bus.busy}, 32'h4);
    check("reset data", bus.resp_data, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    run("mul", MD_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 10);
    run("mulh", MD_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 10);
    run("mulhsu", MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 10);
    run("mulhu", MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 10);

    // Interleaved so no division repeats the operands of the one before it.
    run("div", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
    run("divu", MD_DIVU, 32'd100, 32'd7, 32'd14, 34);
    run("rem", MD_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
    run("remu", MD_REMU, 32'd100, 32'd7, 32'd2, 34);

    run("div by 0", MD_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run("remu by 0", MD_REMU, 32'd5, 32'd0, 32'd5, 1);
    run("div ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run("rem ovf", MD_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);

    // Response held while the consumer stalls.
    issue(MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_resp(lat);
    check("hold latency", lat, 10);
    for (int i = 0; i < 5; i++) begin
      check("hold valid/ready", {bus.resp_valid, bus.req_ready}, 32'h2);
      check("hold data", bus.resp_data, 32'hFFFF_FFFE);
      @(posedge clk); #1;
    end
    handshake();
    check("post-ack valid", bus.resp_valid, 1'b0);
    check("post-ack data kept", bus.resp_data, 32'hFFFF_FFFE);

    // Reset in the middle of a division aborts it without a response.
    issue(MD_DIVU, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    check("mid-div busy", bus.busy, 1'b1);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    check("abort flags", {bus.req_ready, bus.resp_valid, bus.busy}, 32'h4);
    check("abort data", bus.resp_data, 32'h0);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.resp_valid === 1'b1) seen++;
    end
    check("abort no resp", seen, 0);

    run("f divu", MD_DIVU, 32'd100, 32'd7, 32'd14, 34);
`ifdef RV_MULDIV_FUSE_EN
    run("f remu", MD_REMU, 32'd100, 32'd7, 32'd2, 1);
`else
    run("f remu", MD_REMU, 32'd100, 32'd7, 32'd2, 34);
`endif
    run("f remu new", MD_REMU, 32'd100, 32'd8, 32'd4, 34);
    run("f mul", MD_MUL, 32'd3, 32'd5, 32'd15, 10);
`ifdef RV_MULDIV_FUSE_EN
    run("f divu after mul", MD_DIVU, 32'd100, 32'd8, 32'd12, 1);
`else
    run("f divu after mul", MD_DIVU, 32'd100, 32'd8, 32'd12, 34);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
